// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the DDR port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_IF_BUSY = 2'd1,
        ARB_LS_BUSY = 2'd2
    } arb_state_e;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_LS = 1'b1;

    localparam int ARB_ADDR_W = 19;
    localparam int ARB_DATA_W = 128;
    localparam int ARB_MASK_W = 128;

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational grant select between fetch and load/store.
// Define ARB_RR_EN for round-robin; default is load/store-over-fetch priority.
module mem_arb_grant
    import mem_arb_pkg::*;
(
    input  logic       i_if_valid,
    input  logic       i_ls_valid,
    input  logic       i_if_flush,
    input  logic       i_rr_ptr,
    output logic [1:0] o_grant
);

    logic w_if_req;
    logic w_pick_if;

    // A fetch raised together with a redirect is stale and never competes.
    assign w_if_req = i_if_valid && !i_if_flush;

`ifdef ARB_RR_EN
    // i_rr_ptr holds the id served last; the other side wins a tie.
    assign w_pick_if = w_if_req && (!i_ls_valid || (i_rr_ptr == REQ_LS));
`else
    logic w_unused_rr;
    assign w_unused_rr = i_rr_ptr;
    assign w_pick_if   = w_if_req && !i_ls_valid;
`endif

    always_comb begin
        o_grant = '0;
        if (w_pick_if)       o_grant[REQ_IF] = 1'b1;
        else if (i_ls_valid) o_grant[REQ_LS] = 1'b1;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing the DDR port between IFU fetch and load/store.
// Optional ARB_RR_EN selects round-robin arbitration inside mem_arb_grant.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = ARB_ADDR_W,
    parameter int DATA_WIDTH = ARB_DATA_W,
    parameter int MASK_WIDTH = ARB_MASK_W
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  if_valid,
    output logic                  if_ready,
    input  logic [63:0]           if_addr,
    output logic                  if_done,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  if_flush,
    input  logic                  ls_valid,
    output logic                  ls_ready,
    input  logic [63:0]           ls_addr,
    input  logic                  ls_we,
    input  logic [MASK_WIDTH-1:0] ls_wmask,
    input  logic [DATA_WIDTH-1:0] ls_wdata,
    output logic                  ls_done,
    output logic [DATA_WIDTH-1:0] ls_rdata,
    output logic                  ddr_ce,
    output logic                  ddr_we,
    output logic [ADDR_WIDTH-1:0] ddr_index,
    output logic [MASK_WIDTH-1:0] ddr_wmask,
    output logic [DATA_WIDTH-1:0] ddr_wdata,
    input  logic                  ddr_done,
    input  logic [DATA_WIDTH-1:0] ddr_rdata
);

    arb_state_e            r_state;
    arb_state_e            w_next_state;
    logic                  r_rr;
    logic                  r_squash;
    logic                  r_if_ready;
    logic                  r_ls_ready;
    logic                  r_if_done;
    logic                  r_ls_done;
    logic [DATA_WIDTH-1:0] r_if_rdata;
    logic [DATA_WIDTH-1:0] r_ls_rdata;
    logic                  r_ddr_ce;
    logic                  r_ddr_we;
    logic [ADDR_WIDTH-1:0] r_ddr_index;
    logic [MASK_WIDTH-1:0] r_ddr_wmask;
    logic [DATA_WIDTH-1:0] r_ddr_wdata;

    logic [1:0]            w_grant;
    logic                  w_idle;
    logic                  w_gnt_if;
    logic                  w_gnt_ls;
    logic                  w_complete;
    logic                  w_if_deliver;
    logic                  w_ls_complete;
    logic                  w_unused_addr;

    assign w_unused_addr = ^{if_addr[63:ADDR_WIDTH+3], if_addr[2:0],
                             ls_addr[63:ADDR_WIDTH+3], ls_addr[2:0]};

    mem_arb_grant u_grant (
        .i_if_valid (if_valid),
        .i_ls_valid (ls_valid),
        .i_if_flush (if_flush),
        .i_rr_ptr   (r_rr),
        .o_grant    (w_grant)
    );

    assign w_idle        = (r_state == ARB_IDLE);
    assign w_gnt_if      = w_idle && w_grant[REQ_IF];
    assign w_gnt_ls      = w_idle && w_grant[REQ_LS];
    // ddr_done outside a transaction is stray and ignored.
    assign w_complete    = ddr_done && !w_idle;
    assign w_ls_complete = ddr_done && (r_state == ARB_LS_BUSY);
    // A redirect seen on the completion cycle itself still kills the response.
    assign w_if_deliver  = ddr_done && (r_state == ARB_IF_BUSY) && !(r_squash || if_flush);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= ARB_IDLE;
        else          r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (w_gnt_ls)      w_next_state = ARB_LS_BUSY;
                else if (w_gnt_if) w_next_state = ARB_IF_BUSY;
            end
            ARB_IF_BUSY,
            ARB_LS_BUSY: begin
                if (ddr_done) w_next_state = ARB_IDLE;
            end
            default: w_next_state = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rr        <= REQ_IF;
            r_squash    <= 1'b0;
            r_if_ready  <= 1'b0;
            r_ls_ready  <= 1'b0;
            r_if_done   <= 1'b0;
            r_ls_done   <= 1'b0;
            r_if_rdata  <= '0;
            r_ls_rdata  <= '0;
            r_ddr_ce    <= 1'b0;
            r_ddr_we    <= 1'b0;
            r_ddr_index <= '0;
            r_ddr_wmask <= '0;
            r_ddr_wdata <= '0;
        end else begin
            r_if_ready <= w_gnt_if;
            r_ls_ready <= w_gnt_ls;
            r_if_done  <= w_if_deliver;
            r_ls_done  <= w_ls_complete;

            if (w_gnt_ls) begin
                r_ddr_ce    <= 1'b1;
                r_ddr_we    <= ls_we;
                r_ddr_index <= ls_addr[ADDR_WIDTH+2:3];
                r_ddr_wmask <= ls_wmask;
                r_ddr_wdata <= ls_wdata;
                r_rr        <= REQ_LS;
            end else if (w_gnt_if) begin
                r_ddr_ce    <= 1'b1;
                r_ddr_we    <= 1'b0;
                r_ddr_index <= if_addr[ADDR_WIDTH+2:3];
                r_ddr_wmask <= '0;
                r_rr        <= REQ_IF;
            end else if (w_complete) begin
                r_ddr_ce    <= 1'b0;
                r_ddr_we    <= 1'b0;
                r_ddr_wmask <= '0;
            end

            if (w_if_deliver)  r_if_rdata <= ddr_rdata;
            if (w_ls_complete) r_ls_rdata <= ddr_rdata;

            if (w_complete)
                r_squash <= 1'b0;
            else if ((r_state == ARB_IF_BUSY) && if_flush)
                r_squash <= 1'b1;
        end
    end

    assign if_ready  = r_if_ready;
    assign ls_ready  = r_ls_ready;
    assign if_done   = r_if_done;
    assign ls_done   = r_ls_done;
    assign if_rdata  = r_if_rdata;
    assign ls_rdata  = r_ls_rdata;
    assign ddr_ce    = r_ddr_ce;
    assign ddr_we    = r_ddr_we;
    assign ddr_index = r_ddr_index;
    assign ddr_wmask = r_ddr_wmask;
    assign ddr_wdata = r_ddr_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests, DDR latency model, decoupled monitor.
module tb_mem_arbiter;

    localparam int AW = 19;
    localparam int DW = 128;

    localparam logic [DW-1:0] RA5 = {16{8'hA5}};
    localparam logic [DW-1:0] WS1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [DW-1:0] RS1 = {16{8'h55}};
    localparam logic [DW-1:0] RF1 = {8{16'hF00D}};
    localparam logic [DW-1:0] RL1 = {4{32'hC0DE_1234}};
    localparam logic [DW-1:0] RF2 = {4{32'h1357_9BDF}};
    localparam logic [DW-1:0] RL2 = {4{32'h2468_ACE0}};
    localparam logic [DW-1:0] RX1 = {16{8'h3C}};
    localparam logic [DW-1:0] RF3 = {4{32'hFACE_B00C}};
    localparam logic [DW-1:0] RX2 = {16{8'h77}};
    localparam logic [DW-1:0] RZ1 = {16{8'hEE}};
    localparam logic [DW-1:0] RN1 = {4{32'h0BAD_F00D}};

    logic          clock;
    logic          reset_n;
    logic          if_valid, if_ready, if_done, if_flush;
    logic [63:0]   if_addr;
    logic [DW-1:0] if_rdata;
    logic          ls_valid, ls_ready, ls_we, ls_done;
    logic [63:0]   ls_addr;
    logic [DW-1:0] ls_wmask, ls_wdata, ls_rdata;
    logic          ddr_ce, ddr_we, ddr_done;
    logic [AW-1:0] ddr_index;
    logic [DW-1:0] ddr_wmask, ddr_wdata, ddr_rdata;

    mem_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .if_valid(if_valid), .if_ready(if_ready), .if_addr(if_addr),
        .if_done(if_done), .if_rdata(if_rdata), .if_flush(if_flush),
        .ls_valid(ls_valid), .ls_ready(ls_ready), .ls_addr(ls_addr), .ls_we(ls_we),
        .ls_wmask(ls_wmask), .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
        .ddr_ce(ddr_ce), .ddr_we(ddr_we), .ddr_index(ddr_index), .ddr_wmask(ddr_wmask),
        .ddr_wdata(ddr_wdata), .ddr_done(ddr_done), .ddr_rdata(ddr_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic          ls;
        logic          we;
        logic [AW-1:0] idx;
        logic [DW-1:0] wmask;
        logic [DW-1:0] wdata;
    } gnt_t;

    gnt_t          exp_gnt[$];
    logic [DW-1:0] exp_if[$];
    logic [DW-1:0] exp_ls[$];
    logic [DW-1:0] ddr_data_q[$];

    task automatic push_gnt(input logic ls, input logic we, input logic [AW-1:0] idx,
                            input logic [DW-1:0] wmask, input logic [DW-1:0] wdata,
                            input logic [DW-1:0] rdata);
        gnt_t g;
        g.ls = ls; g.we = we; g.idx = idx; g.wmask = wmask; g.wdata = wdata;
        exp_gnt.push_back(g);
        ddr_data_q.push_back(rdata);
    endtask

    // DDR model: completes ddr_lat cycles after it first sees ddr_ce
    int            ddr_lat = 3;
    int            ddr_cnt = 0;
    logic          ddr_busy = 1'b0;
    logic [DW-1:0] ddr_cur;

    always @(negedge clock) begin
        if (!reset_n) begin
            ddr_busy = 1'b0;
            ddr_done = 1'b0;
        end else if (ddr_done) begin
            ddr_done  = 1'b0;
            ddr_rdata = {4{32'hDEAD_BEEF}};
        end else if (ddr_ce && !ddr_busy) begin
            ddr_busy = 1'b1;
            ddr_cnt  = ddr_lat;
            ddr_cur  = (ddr_data_q.size() > 0) ? ddr_data_q.pop_front() : '0;
        end else if (ddr_busy) begin
            ddr_cnt--;
            if (ddr_cnt == 0) begin
                ddr_done  = 1'b1;
                ddr_rdata = ddr_cur;
                ddr_busy  = 1'b0;
            end
        end
    end

    // Monitor: grant/stability/response checks against the scoreboard queues
    logic m_prev_ce, m_prev_ifd, m_prev_lsd, m_rise;
    gnt_t m_g, m_cur;
    int   if_done_cnt = 0;

    always @(negedge clock) begin
        if (!reset_n) begin
            m_prev_ce  = 1'b0;
            m_prev_ifd = 1'b0;
            m_prev_lsd = 1'b0;
        end else begin
            m_rise = ddr_ce && !m_prev_ce;
            if (m_rise) begin
                if (exp_gnt.size() == 0) begin
                    chk("grant_unexpected", 1'b1, 1'b0);
                end else begin
                    m_g = exp_gnt.pop_front();
                    chk("grant_if_ready", if_ready, !m_g.ls);
                    chk("grant_ls_ready", ls_ready, m_g.ls);
                    chk("grant_we", ddr_we, m_g.we);
                    chk("grant_index", ddr_index, m_g.idx);
                    chk("grant_wmask", ddr_wmask, m_g.wmask);
                    if (m_g.we) chk("grant_wdata", ddr_wdata, m_g.wdata);
                end
                m_cur.we = ddr_we; m_cur.idx = ddr_index;
                m_cur.wmask = ddr_wmask; m_cur.wdata = ddr_wdata;
            end else begin
                if (if_ready || ls_ready) chk("ready_without_grant", {if_ready, ls_ready}, 2'b00);
                if (ddr_ce) begin
                    chk("stable_we", ddr_we, m_cur.we);
                    chk("stable_index", ddr_index, m_cur.idx);
                    chk("stable_wmask", ddr_wmask, m_cur.wmask);
                    chk("stable_wdata", ddr_wdata, m_cur.wdata);
                end
            end
            if (if_done) begin
                if_done_cnt++;
                if (m_prev_ifd) chk("if_done_width", 1'b1, 1'b0);
                if (exp_if.size() == 0) chk("if_done_unexpected", 1'b1, 1'b0);
                else chk("if_rdata", if_rdata, exp_if.pop_front());
            end
            if (ls_done) begin
                if (m_prev_lsd) chk("ls_done_width", 1'b1, 1'b0);
                if (exp_ls.size() == 0) chk("ls_done_unexpected", 1'b1, 1'b0);
                else chk("ls_rdata", ls_rdata, exp_ls.pop_front());
            end
            m_prev_ce  = ddr_ce;
            m_prev_ifd = if_done;
            m_prev_lsd = ls_done;
        end
    end

    task automatic req_if(input logic [63:0] a);
        if_addr  = a;
        if_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (if_ready) break;
        end
        chk("if_ready_wait", if_ready, 1'b1);
        if_valid = 1'b0;
    endtask

    task automatic req_ls(input logic [63:0] a, input logic we,
                          input logic [DW-1:0] m, input logic [DW-1:0] d);
        ls_addr  = a;
        ls_we    = we;
        ls_wmask = m;
        ls_wdata = d;
        ls_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (ls_ready) break;
        end
        chk("ls_ready_wait", ls_ready, 1'b1);
        ls_valid = 1'b0;
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (exp_gnt.size() == 0 && exp_if.size() == 0 && exp_ls.size() == 0 &&
                !ddr_ce && !ddr_busy && !ddr_done) begin
                ok = 1'b1;
                break;
            end
        end
        chk("idle_wait", ok, 1'b1);
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt0;
        logic seen;
        reset_n = 1'b0;
        if_valid = 0; if_flush = 0; if_addr = '0;
        ls_valid = 0; ls_we = 0; ls_addr = '0; ls_wmask = '0; ls_wdata = '0;
        ddr_done = 0; ddr_rdata = '0;
        #1;
        chk("rst_if_ready", if_ready, 0);
        chk("rst_ls_ready", ls_ready, 0);
        chk("rst_if_done", if_done, 0);
        chk("rst_ls_done", ls_done, 0);
        chk("rst_ddr_ce", ddr_ce, 0);
        chk("rst_ddr_we", ddr_we, 0);
        chk("rst_ddr_index", ddr_index, 0);
        chk("rst_ddr_wmask", ddr_wmask, 0);
        chk("rst_ddr_wdata", ddr_wdata, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_ls_rdata", ls_rdata, 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        // Single fetch
        push_gnt(0, 0, 19'h2, '0, '0, RA5);
        exp_if.push_back(RA5);
        req_if(64'h8000_0010);
        wait_idle();
        chk("single_fetch_done_count", if_done_cnt, 1);

        // Contest 1: store wins, fetch follows after one idle cycle
        push_gnt(1, 1, 19'h8, '1, WS1, RS1);
        exp_ls.push_back(RS1);
        push_gnt(0, 0, 19'h20, '0, '0, RF1);
        exp_if.push_back(RF1);
        fork
            req_ls(64'h8000_0040, 1'b1, '1, WS1);
            req_if(64'h8000_0100);
            begin
                seen = 1'b0;
                for (int i = 0; i < 100; i++) begin
                    @(negedge clock);
                    if (ls_done) begin seen = 1'b1; break; end
                end
                chk("contest1_ls_done_seen", seen, 1'b1);
                @(negedge clock);
                chk("contest1_if_after_idle", if_ready, 1'b1);
            end
        join
        wait_idle();

        // Single load, DDR latency 10 (monitor checks field stability each cycle)
        ddr_lat = 10;
        push_gnt(1, 0, 19'h2468B, '0, '0, RL1);
        exp_ls.push_back(RL1);
        req_ls(64'h0000_0000_0012_3458, 1'b0, '0, {8{16'h9999}});
        wait_idle();
        ddr_lat = 3;

        // Contest 2: load was served last
`ifdef ARB_RR_EN
        push_gnt(0, 0, 19'h40, '0, '0, RF2);
        push_gnt(1, 0, 19'h60, '0, '0, RL2);
`else
        push_gnt(1, 0, 19'h60, '0, '0, RL2);
        push_gnt(0, 0, 19'h40, '0, '0, RF2);
`endif
        exp_if.push_back(RF2);
        exp_ls.push_back(RL2);
        fork
            req_if(64'h8000_0200);
            req_ls(64'h8000_0300, 1'b0, '0, '0);
        join
        wait_idle();

        // Fetch raised together with flush is not granted
        if_addr = 64'h8000_0400; if_valid = 1'b1; if_flush = 1'b1;
        @(negedge clock);
        chk("flushreq_if_ready", if_ready, 0);
        chk("flushreq_ddr_ce", ddr_ce, 0);
        if_valid = 1'b0; if_flush = 1'b0;
        @(negedge clock);
        chk("flushreq_if_ready2", if_ready, 0);
        chk("flushreq_ddr_ce2", ddr_ce, 0);

        // Redirect one cycle after grant squashes the response
        cnt0 = if_done_cnt;
        push_gnt(0, 0, 19'h50, '0, '0, RX1);
        req_if(64'h8000_0280);
        @(negedge clock);
        if_flush = 1'b1;
        @(negedge clock);
        if_flush = 1'b0;
        wait_idle();
        chk("squash_no_done", if_done_cnt, cnt0);
        chk("squash_if_rdata_held", if_rdata, RF2);

        // Next fetch proceeds normally
        push_gnt(0, 0, 19'h52, '0, '0, RF3);
        exp_if.push_back(RF3);
        req_if(64'h8000_0290);
        wait_idle();

        // Redirect exactly on the ddr_done cycle
        cnt0 = if_done_cnt;
        push_gnt(0, 0, 19'h54, '0, '0, RX2);
        req_if(64'h8000_02A0);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            #1;
            if (ddr_done) begin seen = 1'b1; break; end
        end
        chk("late_flush_done_seen", seen, 1'b1);
        if_flush = 1'b1;
        @(negedge clock);
        if_flush = 1'b0;
        wait_idle();
        chk("late_squash_no_done", if_done_cnt, cnt0);
        chk("late_squash_if_rdata", if_rdata, RF3);

        // Reset during LS_BUSY aborts without a done
        ddr_lat = 10;
        push_gnt(1, 0, 19'h70, '0, '0, RZ1);
        req_ls(64'h8000_0380, 1'b0, '0, '0);
        repeat (3) @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("midrst_ddr_ce", ddr_ce, 0);
        chk("midrst_ls_done", ls_done, 0);
        chk("midrst_ls_rdata", ls_rdata, 0);
        @(negedge clock);
        chk("midrst_ls_done2", ls_done, 0);
        chk("midrst_ddr_ce2", ddr_ce, 0);
        reset_n = 1'b1;
        ddr_lat = 3;
        @(negedge clock);
        push_gnt(1, 0, 19'h71, '0, '0, RN1);
        exp_ls.push_back(RN1);
        req_ls(64'h8000_0388, 1'b0, '0, '0);
        wait_idle();

        chk("end_gnt_queue", exp_gnt.size(), 0);
        chk("end_if_queue", exp_if.size(), 0);
        chk("end_ls_queue", exp_ls.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single DDR port between the instruction-fetch requester and the load/store requester. Sits between the frontend IFU (pc_index_valid/ready/done/read_inst) and the DDR model.
- Arbitrates between the two requesters.
- Registers one outstanding transaction at a time.
- Returns completion and read data to the owning requester only.
- Squashes in-flight fetches on redirect.

Parameters:
ADDR_WIDTH, 19, DDR index width; index = req_addr[ADDR_WIDTH+2:3]
DATA_WIDTH, 128, DDR data width and fetch line width
MASK_WIDTH, 128, bit write mask width (equals DATA_WIDTH)

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
if_valid  in  1  fetch request; held until if_ready
if_ready  out  1  one-cycle grant pulse for fetch
if_addr  in  64  fetch byte address (pc_index)
if_done  out  1  one-cycle fetch completion
if_rdata  out  DATA_WIDTH  fetch data, valid with if_done
if_flush  in  1  redirect; squash pending or in-flight fetch
ls_valid  in  1  load/store request; held until ls_ready
ls_ready  out  1  one-cycle grant pulse for load/store
ls_addr  in  64  load/store byte address
ls_we  in  1  1 = store
ls_wmask  in  MASK_WIDTH  store bit mask
ls_wdata  in  DATA_WIDTH  store data
ls_done  out  1  one-cycle load/store completion
ls_rdata  out  DATA_WIDTH  load data, valid with ls_done
ddr_ce  out  1  DDR chip enable; held high through the transaction
ddr_we  out  1  DDR write enable
ddr_index  out  ADDR_WIDTH  DDR word index
ddr_wmask  out  MASK_WIDTH  DDR write mask
ddr_wdata  out  DATA_WIDTH  DDR write data
ddr_done  in  1  DDR completion pulse
ddr_rdata  in  DATA_WIDTH  DDR read data, valid with ddr_done

Behaviour:
- Clock and reset: single clock `clock`; reset_n is asynchronous, active-low.
- Reset values: all outputs 0, FSM = IDLE, squash flag = 0, rr pointer = 0.
- FSM states: IDLE, IF_BUSY, LS_BUSY.
- IDLE:
  - Fixed priority, load/store over fetch.
  - If ls_valid: register addr/we/wmask/wdata into the ddr_* outputs, pulse ls_ready, go to LS_BUSY.
  - Else if if_valid && !if_flush: register the fetch request (ddr_we = 0, ddr_wmask = 0), pulse if_ready, go to IF_BUSY.
  - Fetch request arriving together with if_flush is not granted.
- Grant timing: ddr_ce rises on the clock edge after the grant cycle. The ready pulse is registered in that same edge (ready high the cycle ddr_ce first goes high). The requester drops valid after seeing ready.
- BUSY states:
  - ddr_ce and the ddr_* fields stay stable until the cycle ddr_done = 1.
  - On that edge: ddr_ce, ddr_we, ddr_wmask are cleared; FSM returns to IDLE.
  - The owner's done pulses for exactly one cycle. Its rdata is registered from ddr_rdata and holds until the next done for that requester.
  - Request latency: grant to done = DDR latency + 1 cycle.
- Back-to-back: a new grant may happen in the first IDLE cycle after done, so there is a minimum 1 idle cycle between transactions.
- Redirect squash:
  - if_flush in IF_BUSY (including the ddr_done cycle) sets squash. The DDR transaction still runs to completion; when it completes, if_done is suppressed and if_rdata is not updated. squash clears on return to IDLE.
  - if_flush in LS_BUSY or IDLE with no fetch has no effect.
- Rules on ddr_done:
  - ddr_done while IDLE is ignored.
  - ddr_done while the requester valid is already high for the next request does not shorten the mandatory IDLE cycle.
- Reset mid-transaction: FSM returns to IDLE immediately and ddr_ce drops; no done is generated.
- Stores: ls_done is still pulsed; ls_rdata captures ddr_rdata regardless (don't-care for stores).

Optional Feature:
ARB_RR_EN
- Defined: a 1-bit round-robin pointer replaces fixed priority.
  - When both requesters are valid in IDLE, grant goes to the requester not served last.
  - The pointer updates on every grant.
  - A single valid requester is always granted immediately.
- Undefined: strict load/store-over-fetch priority, as in IDLE above.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state enum (ARB_IDLE=2'd0, ARB_IF_BUSY=2'd1, ARB_LS_BUSY=2'd2);
  - requester id constants (REQ_IF=1'b0, REQ_LS=1'b1);
  - default width constants.
- One sub-module, mem_arb_grant: combinational grant select taking the two valids, if_flush and the rr pointer, returning a one-hot grant. It contains the only ARB_RR_EN-dependent logic.
- The FSM, request registers and response registers stay in mem_arbiter.

Test Plan:
- Single fetch: if_valid, if_addr=64'h8000_0010, DDR done after 3 cycles with rdata=128'hA5.. -> if_ready 1 pulse, ddr_index=19'h2, ddr_we=0, if_done 1 pulse with if_rdata=128'hA5.., ls_done stays 0.
- Simultaneous requests: if_valid and ls_valid (store, addr 64'h8000_0040, full mask) in the same cycle.
  - Fixed priority: store granted first (ddr_we=1, index 19'h8); fetch granted only after ls_done plus 1 idle cycle.
  - With ARB_RR_EN: the second simultaneous contest is won by the requester that lost the first.
- Redirect mid-fetch: if_flush pulsed 1 cycle after if_ready -> DDR still completes; if_done never asserts; if_rdata keeps its previous value; next fetch granted normally.
- Flush at request: if_valid and if_flush in the same IDLE cycle -> no if_ready, ddr_ce stays 0.
- Reset mid-transaction: reset_n low during LS_BUSY -> ddr_ce=0 and FSM IDLE asynchronously, no ls_done; after release a new load completes with correct data.
- Stability: in each BUSY state, ddr_index/ddr_wdata/ddr_wmask are checked constant every cycle until ddr_done, with a DDR latency of 10 cycles.
